auth_sequencer: RTL and testbench

Challenge-response sequencer for the authentication datapath. On a start request it samples the free-running 16-bit LFSR output as a challenge, presents it to the external responder, and accepts a response through a valid/ready handshake. It checks the response against a keyed transform of the challenge and reports pass or fail. Consecutive failures are counted, and the block locks out after a configurable limit. It sits between the LFSR (`lfsr_q` is wired from the LFSR `d_out`) and the top-level I/O.

---
 rtl/auth_pkg.sv | 27 ++
 rtl/auth_wait_timer.sv | 33 +++
 rtl/auth_sequencer.sv | 166 ++++++++++++++++
 tb/tb_auth_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// auth_pkg: shared FSM state encoding, default key and expected-response transform.
// Rev 1.0
`default_nettype none

package auth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_LOCK  = 3'd4
  } auth_state_e;

  localparam logic [15:0] AUTH_KEY_DEFAULT = 16'hA5C3;

  // rotl16(chal ^ key, 3), no width growth
  function automatic logic [15:0] auth_expected(input logic [15:0] chal,
                                                input logic [15:0] key);
    logic [15:0] mixed;
    mixed = chal ^ key;
    return {mixed[12:0], mixed[15:13]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/auth_wait_timer.sv
// auth_wait_timer: 8-bit WAIT-phase cycle counter flagging the last allowed cycle.
// Rev 1.0
`default_nettype none

module auth_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

`default_nettype wire

// File: rtl/auth_sequencer.sv
// auth_sequencer: challenge-response round control with anti-replay, timeout and lockout.
// Rev 1.0
`default_nettype none

module auth_sequencer
  import auth_pkg::*;
#(
  parameter logic [15:0] KEY            = AUTH_KEY_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] lfsr_q,
  output logic [15:0] chal,
  output logic        chal_valid,
  input  logic [15:0] resp,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic        auth_pass,
  output logic        auth_fail,
  output logic        locked,
  output logic [1:0]  fail_cnt
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_FAILS);

  auth_state_e state_q, state_d;

  logic [15:0] last_chal;
  logic [15:0] resp_r;
  logic [15:0] exp_resp;
  logic [1:0]  fail_cnt_next;
  logic        lock_next;
  logic        timer_expired;

  logic load_chal;
  logic timer_clear;
  logic capture_resp;
  logic clr_flags;
  logic round_pass;
  logic round_fail;

  assign exp_resp      = auth_expected(chal, KEY);
  assign fail_cnt_next = (fail_cnt == MAX_CNT) ? fail_cnt : fail_cnt + 2'd1;
  assign lock_next     = (fail_cnt_next == MAX_CNT);

  auth_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == ST_WAIT),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_chal    = 1'b0;
    timer_clear  = 1'b0;
    capture_resp = 1'b0;
    clr_flags    = 1'b0;
    round_pass   = 1'b0;
    round_fail   = 1'b0;
    chal_valid   = 1'b0;
    resp_ready   = 1'b0;
    busy         = 1'b0;
    locked       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !locked) begin
          state_d   = ST_GEN;
          clr_flags = 1'b1;
        end
      end
      ST_GEN: begin
        busy      = 1'b1;
        load_chal = 1'b1;
        // A repeat of the previous challenge is resampled rather than issued
        if (lfsr_q != last_chal) begin
          state_d     = ST_WAIT;
          timer_clear = 1'b1;
        end
      end
      ST_WAIT: begin
        busy       = 1'b1;
        chal_valid = 1'b1;
        resp_ready = 1'b1;
        if (resp_valid && resp_ready) begin
          capture_resp = 1'b1;
          state_d      = ST_CHECK;
        end else if (timer_expired) begin
          round_fail = 1'b1;
          state_d    = lock_next ? ST_LOCK : ST_IDLE;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (resp_r == exp_resp) begin
          round_pass = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          round_fail = 1'b1;
          state_d    = lock_next ? ST_LOCK : ST_IDLE;
        end
      end
      ST_LOCK: begin
        locked = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chal      <= 16'h0000;
      last_chal <= 16'h0000;
      resp_r    <= 16'h0000;
      done      <= 1'b0;
      auth_pass <= 1'b0;
      auth_fail <= 1'b0;
      fail_cnt  <= 2'd0;
    end else begin
      done <= round_pass | round_fail;
      if (load_chal) begin
        chal <= lfsr_q;
      end
      if (timer_clear) begin
        last_chal <= lfsr_q;
      end
      if (capture_resp) begin
        resp_r <= resp;
      end
      if (clr_flags) begin
        auth_pass <= 1'b0;
        auth_fail <= 1'b0;
      end
      if (round_pass) begin
        auth_pass <= 1'b1;
        fail_cnt  <= 2'd0;
      end
      if (round_fail) begin
        auth_fail <= 1'b1;
        fail_cnt  <= fail_cnt_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_auth_sequencer.sv
// tb_auth_sequencer: directed-vector bench for auth_sequencer with TIMEOUT_CYCLES=8.
// Rev 1.0
`default_nettype none

module tb_auth_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] lfsr_q;
  logic [15:0] chal;
  logic        chal_valid;
  logic [15:0] resp;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        auth_pass;
  logic        auth_fail;
  logic        locked;
  logic [1:0]  fail_cnt;

  int checks = 0;
  int errors = 0;

  auth_sequencer #(
    .KEY           (16'hA5C3),
    .TIMEOUT_CYCLES(8),
    .MAX_FAILS     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lfsr_q    (lfsr_q),
    .chal      (chal),
    .chal_valid(chal_valid),
    .resp      (resp),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .busy      (busy),
    .done      (done),
    .auth_pass (auth_pass),
    .auth_fail (auth_fail),
    .locked    (locked),
    .fail_cnt  (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, chal_valid, resp_ready, done, auth_pass, auth_fail, locked, fail_cnt[1:0]}
  function automatic logic [8:0] flags();
    return {busy, chal_valid, resp_ready, done, auth_pass, auth_fail, locked, fail_cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start -> GEN -> WAIT; leaves the block in its first WAIT cycle
  task automatic begin_round(input logic [15:0] lfsr_val);
    lfsr_q = lfsr_val;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
  endtask

  // presents a response during the current WAIT cycle and finishes the round
  task automatic answer(input logic [15:0] r);
    resp       = r;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    lfsr_q     = 16'h0000;
    resp       = 16'h0000;
    resp_valid = 1'b0;
    repeat (3) tick();

    check("rst_flags", 32'(flags()), 32'h000);
    check("rst_chal", 32'(chal), 32'h0000);
    reset = 1'b1;
    tick();

    // Pass round
    lfsr_q = 16'h2359;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("gen_flags", 32'(flags()), {23'd0, 9'b1_0_0_0_0_0_0_00});
    tick();
    check("pass_chal", 32'(chal), 32'h2359);
    check("wait_flags", 32'(flags()), {23'd0, 9'b1_1_1_0_0_0_0_00});
    resp       = 16'h34D4;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    check("check_flags", 32'(flags()), {23'd0, 9'b1_0_0_0_0_0_0_00});
    tick();
    check("pass_done", 32'(flags()), {23'd0, 9'b0_0_0_1_1_0_0_00});
    tick();
    check("pass_hold", 32'(flags()), {23'd0, 9'b0_0_0_0_1_0_0_00});

    // Wrong answers up to lockout
    begin_round(16'h1234);
    answer(16'h0000);
    check("fail1", 32'(flags()), {23'd0, 9'b0_0_0_1_0_1_0_01});
    tick();
    begin_round(16'h5555);
    answer(16'h0000);
    check("fail2", 32'(flags()), {23'd0, 9'b0_0_0_1_0_1_0_10});
    tick();
    begin_round(16'h6666);
    answer(16'h0000);
    check("fail3_lock", 32'(flags()), {23'd0, 9'b0_0_0_1_0_1_1_11});
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("lock_start_ignored", 32'(flags()), {23'd0, 9'b0_0_0_0_0_1_1_11});
    reset = 1'b0;
    #1;
    check("lock_reset", 32'(flags()), 32'h000);
    #1;
    reset = 1'b1;
    tick();

    // Timeout: 8 edges after WAIT entry
    begin_round(16'h0ABC);
    repeat (7) tick();
    check("to_before", 32'(flags()), {23'd0, 9'b1_1_1_0_0_0_0_00});
    tick();
    check("to_expire", 32'(flags()), {23'd0, 9'b0_0_0_1_0_1_0_01});
    tick();

    // Response on the expiry edge wins over the timeout
    begin_round(16'h0BCD);
    repeat (7) tick();
    resp       = 16'h7075;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    check("to_resp_check", 32'(flags()), {23'd0, 9'b1_0_0_0_0_0_0_01});
    tick();
    check("to_resp_pass", 32'(flags()), {23'd0, 9'b0_0_0_1_1_0_0_00});
    tick();

    // Replay: same LFSR value twice
    begin_round(16'h2359);
    answer(16'h34D4);
    check("replay_r1", 32'(flags()), {23'd0, 9'b0_0_0_1_1_0_0_00});
    tick();
    begin_round(16'h2359);
    check("replay_gen1", 32'(flags()), {23'd0, 9'b1_0_0_0_0_0_0_00});
    tick();
    check("replay_gen2", 32'(flags()), {23'd0, 9'b1_0_0_0_0_0_0_00});
    lfsr_q = 16'h4B1E;
    tick();
    check("replay_chal", 32'(chal), 32'h4B1E);
    check("replay_wait", 32'(flags()), {23'd0, 9'b1_1_1_0_0_0_0_00});

    // start while busy leaves the challenge alone
    start  = 1'b1;
    lfsr_q = 16'h7777;
    tick();
    start  = 1'b0;
    check("busy_start_chal", 32'(chal), 32'h4B1E);
    check("busy_start_flags", 32'(flags()), {23'd0, 9'b1_1_1_0_0_0_0_00});

    // Asynchronous reset mid-WAIT
    #2;
    reset = 1'b0;
    #1;
    check("midwait_flags", 32'(flags()), 32'h000);
    check("midwait_chal", 32'(chal), 32'h0000);
    #1;
    reset = 1'b1;
    tick();
    check("post_reset_idle", 32'(flags()), 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
